julia_escape_pipe: RTL and testbench
====================================

// Module: julia_escape_pipe
// PURPOSE
// - Pipelined Julia-set escape-time engine between vga_time_generator and the VGA DAC pins.
// - Takes pixel coordinates and sync/blank from the timing generator, runs one z <- z*z + c iteration per stage, one pixel per clock.
// - Outputs a 10-bit RGB colour per pixel, plus HS/VS/BLANK_N delayed by the same fixed latency so they stay aligned with the colour.
// PARAMETERS
// - MAX_ITER  20     number of iteration stages; an iteration count of MAX_ITER means the pixel never escaped (inside the set)
// - X_CENTER  640    pixel column mapped to Re=0
// - Y_CENTER  360    pixel row mapped to Im=0
// - SHIFT     3      coordinate scale: Q4.12 value = (coord - CENTER) << SHIFT
// - THR       16384  escape threshold on |z|^2, in Q4.12 (16384 = 4.0); compared on 18+ bits
// - VS_ACT    1      active level of iVS/oVS
// - HS_ACT    0      active level of iHS/oHS
// - C_RE_INIT 0      reset value of the latched c real part (Q4.12)
// - C_IM_INIT 0      reset value of the latched c imaginary part (Q4.12)
// - GRAY_SH   5      left shift from iteration count to grey level (no-palette build)
// PORTS
// - iVGA_CLK  in   1         pixel clock; the only clock
// - iRST_N    in   1         asynchronous active-low reset
// - iX        in   12        pixel column (CounterX)
// - iY        in   12        pixel row (CounterY)
// - iHS       in   1         horizontal sync
// - iVS       in   1         vertical sync
// - iBLANK_N  in   1         1 = visible pixel
// - iC_RE     in   16        requested c real part, signed Q4.12
// - iC_IM     in   16        requested c imaginary part, signed Q4.12
// - oR,oG,oB  out  10 each   pixel colour
// - oHS,oVS   out  1         delayed syncs
// - oBLANK_N  out  1         delayed blank
// - oITER     out  IW        escape count, IW = $clog2(MAX_ITER+1)
// BEHAVIOUR
// - Reset (async, immediate): all stage registers clear.
//   - oR/oG/oB = 0, oITER = 0, oBLANK_N = 0.
//   - oHS = ~HS_ACT, oVS = ~VS_ACT; the sync delay line fills with these inactive levels.
//   - c register loads C_RE_INIT/C_IM_INIT.
// - Stage 0 (map):
//   - zr = sat16((iX - X_CENTER) <<< SHIFT), zi = sat16((iY - Y_CENTER) <<< SHIFT).
//   - sat16 clamps to -32768..32767. Stage 0 sets iter = 0 and esc = 0.
// - Stages k = 1..MAX_ITER each register {zr, zi, iter, esc, hs, vs, blank}.
//   - esc = 1: zr, zi and iter pass unchanged.
//   - esc = 0: compute mag = (zr*zr + zi*zi) >>> 12.
//   - mag >= THR: set esc = 1; iter and z are held.
//   - otherwise: zr' = sat16(((zr*zr - zi*zi) >>> 12) + cr), zi' = sat16(((2*zr*zi) >>> 12) + ci), iter = iter + 1.
//   - Products are 32-bit signed and sums are kept at 33 bits; truncation is arithmetic shift (toward -inf).
// - Output register: colour is computed from the last stage's iter.
//   - Blank pixels (blank = 0) force colour to 0. oITER always shows iter.
// - Latency L = MAX_ITER + 2 clocks from inputs to outputs (MAX_ITER + 3 with FRACTAL_PALETTE_EN).
//   - oHS/oVS/oBLANK_N are exactly the inputs delayed by L; pulse widths are preserved bit for bit.
// - c latch:
//   - {cr, ci} <= {iC_RE, iC_IM} only on the clock where iVS goes from ~VS_ACT to VS_ACT (edge detected against a registered copy of iVS).
//   - Otherwise c holds, so iC changes mid-frame have no effect until the next frame.
//   - All stages use the current c register. Pixels in flight at the edge are inside vertical blanking and are not required to be consistent.
// - Throughput: one pixel per clock, no stalls, no handshake.
// - Reset mid-frame: outputs drop to reset values at once. After release, oBLANK_N stays 0 for at least L clocks while the pipe refills.
// CONFIGURATION
// - FRACTAL_PALETTE_EN defined:
//   - Adds one registered stage: 16-entry constant RGB ROM indexed by iter[3:0].
//   - iter == MAX_ITER maps to black.
//   - Latency becomes MAX_ITER + 3; the sync delay line is lengthened to match.
// - FRACTAL_PALETTE_EN undefined:
//   - oR = oG = oB = (iter == MAX_ITER) ? 0 : (iter << GRAY_SH), truncated to 10 bits.
// TESTING
// - Reset: hold iRST_N = 0 with random inputs -> oBLANK_N = 0, oHS = 1, oVS = 0, colour = 0, oITER = 0.
// - Centre pixel: c = 0, iX = 640, iY = 360, blank = 1 -> exactly L clocks later oITER = 20, colour 0.
// - Escape count: c = 0, iX = 0, iY = 360 (z0 = -1.25) -> oITER = 2; no-palette grey = 64 on R, G and B.
// - Sync alignment: iHS low for 120 clocks, iVS pattern 5 lines -> identical waveforms on oHS/oVS delayed by exactly L; oBLANK_N matches iBLANK_N delayed by L.
// - c latch: change iC_RE from 0 to 0x1000 mid-frame -> output unchanged until after the next iVS active edge, then uses c = 1.0.
// - Reset mid-stream: pulse iRST_N low for 3 clocks while streaming -> outputs go idle asynchronously; first visible output appears no earlier than L clocks after release.

Source files
------------

// File: rtl/julia_escape_pipe_if.sv
// Pixel bus between the VGA timing generator, the Julia escape pipe and the DAC pins.
// master: timing-generator side (drives coordinates/syncs/c, reads colour).
// slave : the escape pipe.
interface julia_escape_pipe_if #(
  parameter int IW = 5
);
  logic        [11:0]   iX;
  logic        [11:0]   iY;
  logic                 iHS;
  logic                 iVS;
  logic                 iBLANK_N;
  logic signed [15:0]   iC_RE;
  logic signed [15:0]   iC_IM;
  logic        [9:0]    oR;
  logic        [9:0]    oG;
  logic        [9:0]    oB;
  logic                 oHS;
  logic                 oVS;
  logic                 oBLANK_N;
  logic        [IW-1:0] oITER;

  modport master (
    output iX, iY, iHS, iVS, iBLANK_N, iC_RE, iC_IM,
    input  oR, oG, oB, oHS, oVS, oBLANK_N, oITER
  );

  modport slave (
    input  iX, iY, iHS, iVS, iBLANK_N, iC_RE, iC_IM,
    output oR, oG, oB, oHS, oVS, oBLANK_N, oITER
  );
endinterface

// File: rtl/julia_escape_pipe.sv
// Pipelined Julia-set escape-time engine: one z <- z*z + c iteration per
// stage, one pixel per clock, syncs/blank delayed to stay aligned with colour.
// Latency is MAX_ITER + 2 clocks.
// Optional build macro FRACTAL_PALETTE_EN: adds a 16-entry RGB palette stage
// (latency MAX_ITER + 3) instead of the grey ramp.
module julia_escape_pipe #(
  parameter int MAX_ITER  = 20,
  parameter int X_CENTER  = 640,
  parameter int Y_CENTER  = 360,
  parameter int SHIFT     = 3,
  parameter int THR       = 16384,
  parameter int VS_ACT    = 1,
  parameter int HS_ACT    = 0,
  parameter int C_RE_INIT = 0,
  parameter int C_IM_INIT = 0,
  parameter int GRAY_SH   = 5
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_N,
  julia_escape_pipe_if.slave   pix
);

  localparam int   IW      = $clog2(MAX_ITER + 1);
  localparam logic HS_IDLE = (HS_ACT == 0);
  localparam logic VS_IDLE = (VS_ACT == 0);
  localparam logic VS_ON   = (VS_ACT != 0);

  typedef struct packed {
    logic signed [15:0] zr;
    logic signed [15:0] zi;
    logic [IW-1:0]      iter;
    logic               esc;
  } zState_t;

  // Clamp a 33-bit intermediate into the signed Q4.12 range.
  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return 16'sh7fff;
    else if (v < -33'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Pixel coordinate to Q4.12: (coord - center) << SHIFT, saturated.
  function automatic logic signed [15:0] mapCoord(input logic [11:0] c, input int center);
    logic signed [32:0] d;
    d = $signed({21'b0, c}) - 33'(signed'(center));
    d = d <<< SHIFT;
    return sat16(d);
  endfunction

  // One escape-time iteration; escaped pixels pass through untouched.
  function automatic zState_t iterate(input zState_t s,
                                      input logic signed [15:0] cr,
                                      input logic signed [15:0] ci);
    logic signed [31:0] rr;
    logic signed [31:0] ii;
    logic signed [31:0] ri;
    logic signed [32:0] rr33;
    logic signed [32:0] ii33;
    logic signed [32:0] twoRi;
    logic signed [32:0] mag;
    logic signed [32:0] re;
    logic signed [32:0] im;
    zState_t r;
    r     = s;
    rr    = $signed(s.zr) * $signed(s.zr);
    ii    = $signed(s.zi) * $signed(s.zi);
    ri    = $signed(s.zr) * $signed(s.zi);
    rr33  = $signed({rr[31], rr});
    ii33  = $signed({ii[31], ii});
    twoRi = $signed({ri, 1'b0});
    mag   = (rr33 + ii33) >>> 12;
    re    = ((rr33 - ii33) >>> 12) + 33'(cr);
    im    = (twoRi >>> 12) + 33'(ci);
    if (!s.esc) begin
      if (mag >= 33'(signed'(THR))) begin
        r.esc = 1'b1;
      end else begin
        r.zr   = sat16(re);
        r.zi   = sat16(im);
        r.iter = s.iter + IW'(1);
      end
    end
    return r;
  endfunction

  // Grey ramp used when no palette is built in; inside-set pixels are black.
  function automatic logic [29:0] greyColour(input logic [IW-1:0] it);
    logic [31:0] t;
    if (it == IW'(MAX_ITER))
      return 30'd0;
    t = 32'(it) << GRAY_SH;
    return {t[9:0], t[9:0], t[9:0]};
  endfunction

  // Latched constant c and the registered iVS used for frame-edge detection.
  logic signed [15:0] cRe;
  logic signed [15:0] cIm;
  logic               vsPrev;

  // Iteration pipeline: index 0 is the map stage, 1..MAX_ITER the iterations.
  zState_t stPipe    [0:MAX_ITER];
  zState_t stNext    [1:MAX_ITER];
  logic    hsPipe    [0:MAX_ITER];
  logic    vsPipe    [0:MAX_ITER];
  logic    blankPipe [0:MAX_ITER];

  // Source of the output register (last stage, or palette stage).
  logic [IW-1:0] srcIter;
  logic [29:0]   srcColour;
  logic          srcHs;
  logic          srcVs;
  logic          srcBlank;

  // Capture c on the inactive-to-active transition of iVS only.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vsPrev <= VS_IDLE;
      cRe    <= 16'(signed'(C_RE_INIT));
      cIm    <= 16'(signed'(C_IM_INIT));
    end else begin
      vsPrev <= pix.iVS;
      if ((pix.iVS == VS_ON) && (vsPrev != VS_ON)) begin
        cRe <= pix.iC_RE;
        cIm <= pix.iC_IM;
      end
    end
  end

  // Next-state of every iteration stage from its predecessor.
  always_comb begin
    for (int k = 1; k <= MAX_ITER; k++) begin
      stNext[k] = iterate(stPipe[k-1], cRe, cIm);
    end
  end

  // Stage registers: map at stage 0, then one iteration per stage.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k <= MAX_ITER; k++) begin
        stPipe[k]    <= '0;
        hsPipe[k]    <= HS_IDLE;
        vsPipe[k]    <= VS_IDLE;
        blankPipe[k] <= 1'b0;
      end
    end else begin
      // stage 0: coordinate map
      stPipe[0].zr   <= mapCoord(pix.iX, X_CENTER);
      stPipe[0].zi   <= mapCoord(pix.iY, Y_CENTER);
      stPipe[0].iter <= '0;
      stPipe[0].esc  <= 1'b0;
      hsPipe[0]      <= pix.iHS;
      vsPipe[0]      <= pix.iVS;
      blankPipe[0]   <= pix.iBLANK_N;
      // stages 1..MAX_ITER: iterations
      for (int k = 1; k <= MAX_ITER; k++) begin
        stPipe[k]    <= stNext[k];
        hsPipe[k]    <= hsPipe[k-1];
        vsPipe[k]    <= vsPipe[k-1];
        blankPipe[k] <= blankPipe[k-1];
      end
    end
  end

`ifdef FRACTAL_PALETTE_EN
  // 16-entry palette indexed by the low iteration bits; inside-set is black.
  function automatic logic [29:0] paletteColour(input logic [IW-1:0] it);
    logic [29:0] c;
    if (it == IW'(MAX_ITER))
      return 30'd0;
    case (it[3:0])
      4'd0:    c = {10'd0,   10'd0,   10'd128};
      4'd1:    c = {10'd0,   10'd64,  10'd255};
      4'd2:    c = {10'd0,   10'd160, 10'd512};
      4'd3:    c = {10'd0,   10'd320, 10'd768};
      4'd4:    c = {10'd64,  10'd512, 10'd1023};
      4'd5:    c = {10'd128, 10'd768, 10'd896};
      4'd6:    c = {10'd256, 10'd1023, 10'd640};
      4'd7:    c = {10'd512, 10'd1023, 10'd384};
      4'd8:    c = {10'd768, 10'd1023, 10'd128};
      4'd9:    c = {10'd1023, 10'd896, 10'd0};
      4'd10:   c = {10'd1023, 10'd640, 10'd0};
      4'd11:   c = {10'd1023, 10'd384, 10'd0};
      4'd12:   c = {10'd1023, 10'd128, 10'd64};
      4'd13:   c = {10'd896, 10'd0,   10'd192};
      4'd14:   c = {10'd640, 10'd0,   10'd384};
      default: c = {10'd384, 10'd0,   10'd256};
    endcase
    return c;
  endfunction

  logic [IW-1:0] palIter;
  logic [29:0]   palColour;
  logic          palHs;
  logic          palVs;
  logic          palBlank;

  // Palette stage: ROM lookup, syncs carried one more clock.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      palIter   <= '0;
      palColour <= '0;
      palHs     <= HS_IDLE;
      palVs     <= VS_IDLE;
      palBlank  <= 1'b0;
    end else begin
      palIter   <= stPipe[MAX_ITER].iter;
      palColour <= paletteColour(stPipe[MAX_ITER].iter);
      palHs     <= hsPipe[MAX_ITER];
      palVs     <= vsPipe[MAX_ITER];
      palBlank  <= blankPipe[MAX_ITER];
    end
  end

  assign srcIter   = palIter;
  assign srcColour = palColour;
  assign srcHs     = palHs;
  assign srcVs     = palVs;
  assign srcBlank  = palBlank;
`else
  assign srcIter   = stPipe[MAX_ITER].iter;
  assign srcColour = greyColour(stPipe[MAX_ITER].iter);
  assign srcHs     = hsPipe[MAX_ITER];
  assign srcVs     = vsPipe[MAX_ITER];
  assign srcBlank  = blankPipe[MAX_ITER];
`endif

  // Output register: blank pixels forced black, iteration count always shown.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pix.oR       <= '0;
      pix.oG       <= '0;
      pix.oB       <= '0;
      pix.oITER    <= '0;
      pix.oHS      <= HS_IDLE;
      pix.oVS      <= VS_IDLE;
      pix.oBLANK_N <= 1'b0;
    end else begin
      pix.oR       <= srcBlank ? srcColour[29:20] : 10'd0;
      pix.oG       <= srcBlank ? srcColour[19:10] : 10'd0;
      pix.oB       <= srcBlank ? srcColour[9:0]   : 10'd0;
      pix.oITER    <= srcIter;
      pix.oHS      <= srcHs;
      pix.oVS      <= srcVs;
      pix.oBLANK_N <= srcBlank;
    end
  end

endmodule

// File: tb/tb_julia_escape_pipe.sv
// Directed bench for julia_escape_pipe: reset state, escape counts, latency,
// sync alignment, c latching on the VS edge and mid-stream reset recovery.
module tb_julia_escape_pipe;

`ifdef FRACTAL_PALETTE_EN
  localparam int L = 23;
`else
  localparam int L = 22;
`endif
  localparam int N_SYNC = 1200;

  logic clk = 1'b0;
  logic rstn;
  int   nAsserts = 0;
  int   nFail = 0;
  logic [2:0] hist [0:N_SYNC-1];

  julia_escape_pipe_if #(.IW(5)) bus ();

  julia_escape_pipe dut (
    .iVGA_CLK (clk),
    .iRST_N   (rstn),
    .pix      (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grey-ramp colour only exists in the default build.
  task automatic chkColour(input string tag, input logic [9:0] exp);
`ifndef FRACTAL_PALETTE_EN
    chk({tag, "_R"}, 32'(bus.oR), 32'(exp));
    chk({tag, "_G"}, 32'(bus.oG), 32'(exp));
    chk({tag, "_B"}, 32'(bus.oB), 32'(exp));
`endif
  endtask

  task automatic drivePix(input logic [11:0] x, input logic [11:0] y, input logic bl);
    bus.iX       = x;
    bus.iY       = y;
    bus.iBLANK_N = bl;
  endtask

  initial begin
    // reset with random inputs
    rstn         = 1'b0;
    bus.iX       = 12'($urandom);
    bus.iY       = 12'($urandom);
    bus.iHS      = 1'($urandom);
    bus.iVS      = 1'($urandom);
    bus.iBLANK_N = 1'($urandom);
    bus.iC_RE    = 16'($urandom);
    bus.iC_IM    = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.iX       = 12'($urandom);
      bus.iHS      = 1'($urandom);
      bus.iVS      = 1'($urandom);
      bus.iBLANK_N = 1'($urandom);
    end
    chk("rst_blank", 32'(bus.oBLANK_N), 32'd0);
    chk("rst_hs",    32'(bus.oHS),      32'd1);
    chk("rst_vs",    32'(bus.oVS),      32'd0);
    chk("rst_iter",  32'(bus.oITER),    32'd0);
    chk("rst_R",     32'(bus.oR),       32'd0);
    chk("rst_G",     32'(bus.oG),       32'd0);
    chk("rst_B",     32'(bus.oB),       32'd0);

    // idle stream, c = 0
    drivePix(12'd640, 12'd360, 1'b0);
    bus.iHS   = 1'b1;
    bus.iVS   = 1'b0;
    bus.iC_RE = 16'sd0;
    bus.iC_IM = 16'sd0;
    rstn      = 1'b1;
    for (int i = 0; i < L + 2; i++) step();

    // centre pixel then escape pixel, one clock each
    drivePix(12'd640, 12'd360, 1'b1);
    step();
    drivePix(12'd0, 12'd360, 1'b1);
    step();
    drivePix(12'd640, 12'd360, 1'b0);
    for (int i = 3; i <= L - 1; i++) step();
    chk("lat_early_blank", 32'(bus.oBLANK_N), 32'd0);
    step();
    chk("centre_blank", 32'(bus.oBLANK_N), 32'd1);
    chk("centre_iter",  32'(bus.oITER),    32'd20);
    chkColour("centre", 10'd0);
    step();
    chk("esc_blank", 32'(bus.oBLANK_N), 32'd1);
    chk("esc_iter",  32'(bus.oITER),    32'd2);
    chkColour("esc", 10'd64);
    step();
    chk("after_blank", 32'(bus.oBLANK_N), 32'd0);
    chkColour("after", 10'd0);

    // sync alignment: 200-clock lines, HS low 120 clocks, VS active 5 lines
    for (int i = 0; i < N_SYNC + L - 1; i++) begin
      if (i < N_SYNC) begin
        bus.iHS      = ((i % 200) < 120) ? 1'b0 : 1'b1;
        bus.iVS      = (i >= 100 && i < 1100) ? 1'b1 : 1'b0;
        bus.iBLANK_N = ((i % 200) >= 130 && (i % 200) < 190) ? 1'b1 : 1'b0;
        bus.iX       = 12'(i % 200);
        hist[i]      = {bus.iHS, bus.iVS, bus.iBLANK_N};
      end else begin
        bus.iHS      = 1'b1;
        bus.iVS      = 1'b0;
        bus.iBLANK_N = 1'b0;
      end
      step();
      if (i >= L - 1)
        chk("sync", 32'({bus.oHS, bus.oVS, bus.oBLANK_N}), 32'(hist[i - L + 1]));
    end

    // c latch: mid-frame change ignored until the next VS active edge
    bus.iC_RE = 16'sh1000;
    drivePix(12'd0, 12'd360, 1'b1);
    for (int i = 0; i < L; i++) step();
    chk("c_hold_iter", 32'(bus.oITER), 32'd2);
    chkColour("c_hold", 10'd64);
    bus.iVS = 1'b1;
    for (int i = 0; i < L + 1; i++) step();
    chk("c_new_iter", 32'(bus.oITER), 32'd1);
    chk("c_new_vs",   32'(bus.oVS),   32'd1);
    chkColour("c_new", 10'd32);
    bus.iVS   = 1'b0;
    bus.iC_RE = 16'sd0;
    for (int i = 0; i < L; i++) step();
    chk("c_keep_iter", 32'(bus.oITER), 32'd1);
    chkColour("c_keep", 10'd32);
    bus.iC_RE = 16'sh1000;

    // reset mid-stream: async drop, c back to its init value, refill latency
    rstn = 1'b0;
    #1;
    chk("mid_rst_blank", 32'(bus.oBLANK_N), 32'd0);
    chk("mid_rst_iter",  32'(bus.oITER),    32'd0);
    chk("mid_rst_hs",    32'(bus.oHS),      32'd1);
    chk("mid_rst_vs",    32'(bus.oVS),      32'd0);
    chkColour("mid_rst", 10'd0);
    for (int i = 0; i < 3; i++) step();
    rstn = 1'b1;
    for (int j = 1; j <= L; j++) begin
      step();
      if (j < L)
        chk("refill_blank", 32'(bus.oBLANK_N), 32'd0);
    end
    chk("refill_vis",  32'(bus.oBLANK_N), 32'd1);
    chk("refill_iter", 32'(bus.oITER),    32'd2);
    chkColour("refill", 10'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
